// File: rtl/tdm_channel_mux_pkg.sv
// Shared definitions for the TDM channel multiplexer: parameter defaults, slot index width
// and sequencer state encoding.
package tdm_channel_mux_pkg;

  localparam int unsigned NUM_CHANNELS_DEF = 4;
  localparam int unsigned DATA_WIDTH_DEF   = 32;
  localparam int unsigned UNDERRUN_CNT_W   = 16;

  function automatic int unsigned slot_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned SLOT_W_DEF = slot_width(NUM_CHANNELS_DEF);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } tdm_state_e;

endpackage

// File: rtl/tdm_channel_mux_if.sv
// Channel-side and TDM-side signal bundle of the channel multiplexer.
interface tdm_channel_mux_if
  import tdm_channel_mux_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
);

  localparam int unsigned SlotW = slot_width(NUM_CHANNELS);

  logic                                   enable;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data;
  logic [NUM_CHANNELS-1:0]                ch_valid;
  logic [NUM_CHANNELS-1:0]                ch_ready;
  logic [DATA_WIDTH-1:0]                  tdm_data;
  logic                                   tdm_valid;
  logic [SlotW-1:0]                       tdm_slot;
  logic                                   frame_start;
  logic [NUM_CHANNELS-1:0]                underrun_flags;
  logic [UNDERRUN_CNT_W-1:0]              underrun_count;

  modport master (
    output enable, ch_data, ch_valid,
    input  ch_ready, tdm_data, tdm_valid, tdm_slot, frame_start, underrun_flags, underrun_count
  );

  modport slave (
    input  enable, ch_data, ch_valid,
    output ch_ready, tdm_data, tdm_valid, tdm_slot, frame_start, underrun_flags, underrun_count
  );

endinterface

// File: rtl/tdm_hold_slot.sv
// One-entry per-channel holding buffer; accepts a refill in the same cycle it is consumed.
module tdm_hold_slot
  import tdm_channel_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_consume,
  output logic                  o_ready,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_take;
  logic                  w_wr;

  assign w_take  = i_consume & r_full;
  assign o_ready = ~r_full | w_take;
  assign w_wr    = i_wr_valid & o_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (w_wr) begin
      r_full <= 1'b1;
      r_data <= i_wr_data;
    end else if (w_take) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/tdm_channel_mux.sv
// Serialises per-channel samples into a fixed TDM slot sequence, flagging and counting
// slots whose holding buffer was empty.
module tdm_channel_mux
  import tdm_channel_mux_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input logic               clk,
  input logic               reset,
  tdm_channel_mux_if.slave  bus
);

  localparam int unsigned     SlotW    = slot_width(NUM_CHANNELS);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(NUM_CHANNELS - 1);

  tdm_state_e                r_state;
  tdm_state_e                w_state_next;
  logic [SlotW-1:0]          r_slot;
  logic [SlotW-1:0]          w_slot_next;
  logic                      w_active;
  logic [NUM_CHANNELS-1:0]   w_consume;
  logic [NUM_CHANNELS-1:0]   w_full;
  logic [NUM_CHANNELS-1:0]   w_ready;
  logic [DATA_WIDTH-1:0]     w_buf_data [NUM_CHANNELS];
  logic                      w_sel_full;
  logic [DATA_WIDTH-1:0]     w_sel_data;

  logic [DATA_WIDTH-1:0]     r_tdm_data;
  logic                      r_tdm_valid;
  logic [SlotW-1:0]          r_tdm_slot;
  logic                      r_frame_start;
  logic [NUM_CHANNELS-1:0]   r_underrun_flags;
  logic [UNDERRUN_CNT_W-1:0] r_underrun_count;

  assign w_active = (r_state != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_next;
      r_slot  <= w_slot_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_slot_next  = r_slot;
    unique case (r_state)
      StIdle: begin
        w_slot_next = '0;
        if (bus.enable) w_state_next = StRun;
      end
      StRun: begin
        if (!bus.enable) w_state_next = StDrain;
      end
      StDrain: begin
        // A re-enable during drain resumes without losing frame alignment.
        if (bus.enable)              w_state_next = StRun;
        else if (r_slot == LastSlot) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    if (w_active) w_slot_next = (r_slot == LastSlot) ? '0 : r_slot + SlotW'(1);
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_hold
    assign w_consume[gi] = w_active && (r_slot == SlotW'(gi));

    tdm_hold_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
      .clk        (clk),
      .reset      (reset),
      .i_wr_valid (bus.ch_valid[gi]),
      .i_wr_data  (bus.ch_data[gi]),
      .i_consume  (w_consume[gi]),
      .o_ready    (w_ready[gi]),
      .o_full     (w_full[gi]),
      .o_data     (w_buf_data[gi])
    );
  end

  assign w_sel_full = w_full[r_slot];
  assign w_sel_data = w_buf_data[r_slot];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tdm_data       <= '0;
      r_tdm_valid      <= 1'b0;
      r_tdm_slot       <= '0;
      r_frame_start    <= 1'b0;
      r_underrun_flags <= '0;
      r_underrun_count <= '0;
    end else if (w_active) begin
      r_tdm_slot    <= r_slot;
      r_frame_start <= (r_slot == '0);
      if (w_sel_full) begin
        r_tdm_data  <= w_sel_data;
        r_tdm_valid <= 1'b1;
      end else begin
        r_tdm_data               <= '0;
        r_tdm_valid              <= 1'b0;
        r_underrun_flags[r_slot] <= 1'b1;
        if (r_underrun_count != '1) r_underrun_count <= r_underrun_count + 1'b1;
      end
    end else begin
      r_tdm_data    <= '0;
      r_tdm_valid   <= 1'b0;
      r_tdm_slot    <= '0;
      r_frame_start <= 1'b0;
    end
  end

  assign bus.ch_ready       = w_ready;
  assign bus.tdm_data       = r_tdm_data;
  assign bus.tdm_valid      = r_tdm_valid;
  assign bus.tdm_slot       = r_tdm_slot;
  assign bus.frame_start    = r_frame_start;
  assign bus.underrun_flags = r_underrun_flags;
  assign bus.underrun_count = r_underrun_count;

endmodule

// File: tb/tb_tdm_channel_mux.sv
// Self-checking bench for tdm_channel_mux: directed phases plus random traffic against a
// per-cycle behavioural model of the slot sequencer and channel buffers.
module tb_tdm_channel_mux;

  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tdm_channel_mux_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) bus ();

  tdm_channel_mux #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit            m_init = 1'b0;
  bit            m_run  = 1'b0;
  bit            m_drain = 1'b0;
  int            m_slot = 0;
  bit            m_full [N];
  logic [DW-1:0] m_buf  [N];
  logic [DW-1:0] e_data  = '0;
  bit            e_valid = 1'b0;
  int            e_slot  = 0;
  bit            e_fs    = 1'b0;
  logic [N-1:0]  e_flags = '0;
  int            e_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !m_full[i] || (m_run && m_slot == i);
    return r;
  endfunction

  // Checks ch_ready, advances the model over one clock edge, then checks registered outputs.
  task automatic tick();
    logic [N-1:0] rdy;
    int s;
    if (m_init) check("ch_ready", 64'(bus.ch_ready), 64'(model_ready()));
    rdy = model_ready();
    if (reset) begin
      m_init = 1'b1; m_run = 1'b0; m_drain = 1'b0; m_slot = 0;
      for (int i = 0; i < N; i++) begin m_full[i] = 1'b0; m_buf[i] = '0; end
      e_data = '0; e_valid = 1'b0; e_slot = 0; e_fs = 1'b0; e_flags = '0; e_count = 0;
    end else if (m_run) begin
      s = m_slot;
      e_slot = s;
      e_fs = (s == 0);
      if (m_full[s]) begin
        e_data = m_buf[s]; e_valid = 1'b1;
      end else begin
        e_data = '0; e_valid = 1'b0; e_flags[s] = 1'b1;
        if (e_count < 65535) e_count++;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.ch_valid[i] && rdy[i]) begin
          m_full[i] = 1'b1; m_buf[i] = bus.ch_data[i];
        end else if (i == s) begin
          m_full[i] = 1'b0;
        end
      end
      if (bus.enable)                  m_drain = 1'b0;
      else if (m_drain && s == N - 1) begin m_run = 1'b0; m_drain = 1'b0; end
      else                             m_drain = 1'b1;
      m_slot = m_run ? (s + 1) % N : 0;
    end else begin
      e_data = '0; e_valid = 1'b0; e_slot = 0; e_fs = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (bus.ch_valid[i] && rdy[i]) begin m_full[i] = 1'b1; m_buf[i] = bus.ch_data[i]; end
      end
      if (bus.enable) m_run = 1'b1;
      m_slot = 0;
    end
    @(posedge clk);
    #1;
    check("tdm_data",       64'(bus.tdm_data),       64'(e_data));
    check("tdm_valid",      64'(bus.tdm_valid),      64'(e_valid));
    check("tdm_slot",       64'(bus.tdm_slot),       64'(e_slot));
    check("frame_start",    64'(bus.frame_start),    64'(e_fs));
    check("underrun_flags", 64'(bus.underrun_flags), 64'(e_flags));
    check("underrun_count", 64'(bus.underrun_count), 64'(e_count));
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.ch_valid = '0;
    bus.ch_data = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Steady streaming of four constant samples
    for (int i = 0; i < N; i++) bus.ch_data[i] = $urandom;
    bus.ch_valid = '1;
    bus.enable = 1'b1;
    repeat (20) tick();
    check("stream_no_underrun", 64'(bus.underrun_flags), 64'(0));

    // Channel 2 starved
    bus.ch_valid = 4'b1011;
    repeat (16) begin
      for (int i = 0; i < N; i++) bus.ch_data[i] = $urandom;
      tick();
    end
    check("starved_ch2_flags", 64'(bus.underrun_flags), 64'(4'b0100));

    // Random traffic, including same-cycle refill and backpressure
    repeat (300) begin
      bus.ch_valid = 4'($urandom);
      for (int i = 0; i < N; i++) bus.ch_data[i] = $urandom;
      bus.enable = ($urandom_range(0, 15) != 0);
      tick();
    end

    // Drop enable at slot 1: frame completes, then idle; re-enable restarts at slot 0
    bus.enable = 1'b1;
    bus.ch_valid = '1;
    for (int k = 0; k < 12 && !(m_run && m_slot == 1); k++) tick();
    check("reached_slot1", 64'(m_slot), 64'(1));
    bus.enable = 1'b0;
    repeat (6) tick();
    check("idle_after_drain", 64'(bus.tdm_valid), 64'(0));
    bus.enable = 1'b1;
    tick();
    tick();
    check("restart_slot0", 64'(bus.tdm_slot), 64'(0));
    repeat (6) tick();

    // Saturate the underrun counter
    bus.ch_valid = '0;
    repeat (70010) tick();
    check("count_saturated", 64'(bus.underrun_count), 64'(16'hFFFF));

    // Fill buffers, then reset mid-frame; held samples must be discarded
    bus.ch_valid = '1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_count", 64'(bus.underrun_count), 64'(0));
    check("post_reset_valid", 64'(bus.tdm_valid), 64'(0));
    reset = 1'b0;
    bus.ch_valid = '0;
    bus.enable = 1'b0;
    tick();
    check("post_reset_ready", 64'(bus.ch_ready), 64'(4'b1111));
    bus.enable = 1'b1;
    repeat (6) tick();
    check("empty_after_reset", 64'(bus.underrun_flags), 64'(4'b1111));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_channel_mux.md
TDM_CHANNEL_MUX -- requirements
Module: tdm_channel_mux

Interface
REQ-001 The module SHALL have parameter NUM_CHANNELS, default 4, the number of TDM slots per frame (at least 2).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, the sample width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port enable, input, 1 bit: request to run the slot sequencer.
REQ-006 The module SHALL have port ch_data, input, NUM_CHANNELS x DATA_WIDTH: per-channel sample.
REQ-007 The module SHALL have port ch_valid, input, NUM_CHANNELS: per-channel sample valid.
REQ-008 The module SHALL have port ch_ready, output, NUM_CHANNELS: per-channel accept.
REQ-009 The module SHALL have port tdm_data, output, DATA_WIDTH: serialized sample feeding the TDM FIR delay line.
REQ-010 The module SHALL have port tdm_valid, output, 1 bit: tdm_data carries a real sample.
REQ-011 The module SHALL have port tdm_slot, output, clog2(NUM_CHANNELS) bits: the channel index of tdm_data.
REQ-012 The module SHALL have port frame_start, output, 1 bit: high when tdm_slot is 0 and the sequencer is active.
REQ-013 The module SHALL have port underrun_flags, output, NUM_CHANNELS: sticky per-channel underrun.
REQ-014 The module SHALL have port underrun_count, output, 16 bits: saturating total underrun count.

Function
REQ-015 Each channel SHALL have a one-entry holding buffer with a full bit.
REQ-016 A transfer on channel i SHALL occur when ch_valid[i] and ch_ready[i] are both high.
REQ-017 ch_ready[i] SHALL equal (not full[i]) or (state is RUN or DRAIN, slot equals i, and full[i]); this allows refill in the same cycle the buffer is consumed.
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-019 IDLE: slot counter held at 0; goes to RUN when enable is high.
REQ-020 RUN: goes to DRAIN when enable is low.
REQ-021 DRAIN: goes to IDLE after the cycle in which slot equals NUM_CHANNELS-1; returns to RUN if enable rises before that.
REQ-022 In RUN and DRAIN, the slot counter SHALL increment every cycle, wrapping from NUM_CHANNELS-1 to 0. There is no stall: the downstream delay line advances every clock.
REQ-023 In a RUN or DRAIN cycle with slot equal to s, if full[s] is high: register tdm_data equal to buf[s], tdm_valid equal to 1, and clear full[s] unless it is refilled in the same cycle.
REQ-024 In a RUN or DRAIN cycle with slot equal to s, if full[s] is low: register tdm_data equal to 0 and tdm_valid equal to 0, set underrun_flags[s], and increment underrun_count, saturating at 0xFFFF.
REQ-025 In a RUN or DRAIN cycle, also register tdm_slot equal to s and frame_start equal to (s == 0).
REQ-026 Latency: outputs SHALL appear one cycle after the slot cycle, and all outputs are registered except ch_ready.
REQ-027 In an IDLE cycle, the registered outputs SHALL be: tdm_valid 0, tdm_data 0, frame_start 0, tdm_slot 0. Buffers keep their contents and no underruns are counted.
REQ-028 A write to a full buffer SHALL be impossible, since ch_ready is low; the data is held upstream and no sample is dropped.
REQ-029 If channel i is written and its slot is consumed in the same cycle, the old sample SHALL be output and the new sample stored, leaving full[i] set.
REQ-030 underrun_flags and underrun_count SHALL clear only on reset.

Reset
REQ-031 On reset the FSM SHALL go to IDLE and the slot counter to 0.
REQ-032 On reset all full bits SHALL clear and buffer data SHALL go to 0.
REQ-033 On reset tdm_data, tdm_valid, tdm_slot, frame_start, underrun_flags and underrun_count SHALL go to 0.
REQ-034 On reset ch_ready SHALL go to all ones from the next cycle.
REQ-035 Reset SHALL take priority over all activity, including a reset mid-frame; a sample held when reset is asserted is discarded.

Structure
REQ-036 The shared package SHALL hold the NUM_CHANNELS and DATA_WIDTH defaults, the slot index width and the FSM state enum (IDLE, RUN, DRAIN).
REQ-037 The per-channel holding register, with its full bit, refill and consume logic, SHALL be one sub-module named tdm_hold_slot, instantiated NUM_CHANNELS times by a generate loop.

Verification
REQ-038 Enable rises after reset with ch_valid held at 1111 and ch_data values A, B, C, D. Required: from 1 cycle after enable, the tdm_slot sequence is 0,1,2,3,0,…, tdm_valid stays 1, tdm_data repeats A,B,C,D, and frame_start is high every 4th cycle.
REQ-039 Channel 2 is never valid while the others stream. Required: tdm_valid is 0 and tdm_data is 0 at slot 2 each frame, underrun_flags is 0100, and underrun_count equals the number of frames.
REQ-040 Channel 0 is written at the same cycle as its slot while holding X, with new value Y. Required: X is output, Y is output one frame later, and no underrun occurs.
REQ-041 Channel 1 holds ch_valid high while its buffer is full. Required: ch_ready[1] is low except in its slot cycle, and each presented value is output exactly once, in order.
REQ-042 Enable is deasserted at slot 1. Required: slots 2 and 3 are still emitted, then the FSM is IDLE with tdm_valid 0; re-enabling restarts at slot 0.
REQ-043 Force 70000 underruns, then assert reset mid-frame. Required: underrun_count saturates at 0xFFFF; one cycle after reset all outputs are 0, the FSM is IDLE and the buffers are empty.
